// File: rtl/tone_sweeper.sv
// rtl/tone_sweeper.sv - stepped-period tone sweep sequencer for a square wave generator
module tone_sweeper #(
    parameter int PERIOD_WIDTH = 32,
    parameter int COUNT_WIDTH  = 8,
    parameter int TICK_CYCLES  = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PERIOD_WIDTH-1:0] start_period,
    input  logic [PERIOD_WIDTH-1:0] delta,
    input  logic [COUNT_WIDTH-1:0]  num_steps,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    gate,
    output logic                    busy,
    output logic                    done
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic signed [PERIOD_WIDTH+1:0] SUM_MIN = (PERIOD_WIDTH+2)'(1);
    localparam logic signed [PERIOD_WIDTH+1:0] SUM_MAX = {2'b00, {PERIOD_WIDTH{1'b1}}};

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t                   state, state_nxt;
    logic [PERIOD_WIDTH-1:0]  period_nxt;
    logic [PERIOD_WIDTH-1:0]  delta_q, delta_nxt;
    logic [COUNT_WIDTH-1:0]   steps_left, steps_nxt;
    logic [TICK_W-1:0]        tick, tick_nxt;
    logic                     gate_nxt, busy_nxt, done_nxt;
    logic signed [PERIOD_WIDTH+1:0] sum;
    logic [PERIOD_WIDTH-1:0]  sat_period;
    logic [PERIOD_WIDTH-1:0]  load_period;

    // Two guard bits so that neither a large positive nor negative step can wrap before clamping.
    always_comb begin
        sum = $signed({2'b00, period}) + $signed({{2{delta_q[PERIOD_WIDTH-1]}}, delta_q});
        if (sum < SUM_MIN) begin
            sat_period = PERIOD_WIDTH'(1);
        end else if (sum > SUM_MAX) begin
            sat_period = {PERIOD_WIDTH{1'b1}};
        end else begin
            sat_period = sum[PERIOD_WIDTH-1:0];
        end
    end

    // A zero start period would silence the downstream generator while gated on.
    assign load_period = (start_period == '0) ? PERIOD_WIDTH'(1) : start_period;

    always_comb begin
        state_nxt  = state;
        period_nxt = period;
        delta_nxt  = delta_q;
        steps_nxt  = steps_left;
        tick_nxt   = tick;
        gate_nxt   = gate;
        done_nxt   = 1'b0;
        if (stop) begin
            if (state == PLAY) begin
                state_nxt = IDLE;
                gate_nxt  = 1'b0;
                tick_nxt  = '0;
            end
        end else if (start) begin
            state_nxt  = PLAY;
            period_nxt = load_period;
            delta_nxt  = delta;
            steps_nxt  = num_steps;
            tick_nxt   = '0;
            gate_nxt   = 1'b1;
        end else if (state == PLAY) begin
            if (tick == TICK_LAST) begin
                tick_nxt = '0;
                if (steps_left != '0) begin
                    period_nxt = sat_period;
                    steps_nxt  = steps_left - COUNT_WIDTH'(1);
                end else begin
                    state_nxt = IDLE;
                    gate_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end else begin
                tick_nxt = tick + TICK_W'(1);
            end
        end
        busy_nxt = (state_nxt == PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period     <= '0;
            delta_q    <= '0;
            steps_left <= '0;
            tick       <= '0;
            gate       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            period     <= period_nxt;
            delta_q    <= delta_nxt;
            steps_left <= steps_nxt;
            tick       <= tick_nxt;
            gate       <= gate_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule
